seq_alu: RTL

Parametrised multi-cycle ALU for the datapath, replacing the purely combinational ALU. It takes operands with a start/done handshake and produces a 2*WIDTH result packed as {HI, LO}. Add, logic, shift and rotate operations complete in one cycle. Mul uses iterative radix-2 Booth and div uses iterative restoring division, so multiplier and divider area is shared across cycles. The control unit holds the bus/Z-load sequence until done is asserted.

---
 rtl/seq_alu.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/done handshake and a {HI, LO} result.
//   Single-cycle ops (add, logic, shift, rotate, neg, not, pass) finish in 1 cycle.
//   mul uses radix-2 Booth over WIDTH cycles (done at WIDTH+1).
//   div uses restoring division over WIDTH cycles plus a sign fixup (done at WIDTH+2).
//   div by zero skips iteration and finishes in 1 cycle.
// Ports:
//   clk, clr_n (async active-low reset)
//   start, opcode[4:0], a, b  : request; sampled only when idle
//   busy                      : operation in flight (never together with done)
//   done                      : one-cycle pulse; result valid
//   result[2W-1:0]            : {HI, LO}; held until the next done
//   div_by_zero               : set with done on div by 0; cleared on the next accepted start
// Optional: define ALU_FLAGS_EN to add registered z/n/v flag outputs.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
`ifdef ALU_FLAGS_EN
  ,
  output logic               z,
  output logic               n,
  output logic               v
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ADD  = 5'b00011,
                         OP_SUB  = 5'b00100, OP_AND  = 5'b00101, OP_OR   = 5'b00110,
                         OP_SHR  = 5'b00111, OP_SHRA = 5'b01000, OP_SHL  = 5'b01001,
                         OP_ROR  = 5'b01010, OP_ROL  = 5'b01011, OP_ADDI = 5'b01100,
                         OP_ANDI = 5'b01101, OP_ORI  = 5'b01110, OP_MUL  = 5'b01111,
                         OP_DIV  = 5'b10000, OP_NEG  = 5'b10001, OP_NOT  = 5'b10010,
                         OP_JR   = 5'b10100, OP_JAL  = 5'b10101;

  // S_EXEC doubles as the done cycle for every operation.
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_FIX} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   opnd_q, opnd_d;     // Booth multiplicand, or divisor magnitude
  logic [WIDTH:0]     hi_q, hi_d;         // Booth accumulator, or partial remainder
  logic [WIDTH-1:0]   lo_q, lo_d;         // Booth multiplier, or dividend/quotient
  logic               qm1_q, qm1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_neg_q, a_neg_d;
  logic               q_neg_q, q_neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               dbz_q, dbz_d;

  logic               cnt_last;
  logic               wr_res;
  logic [2*WIDTH-1:0] res_new;
  logic [WIDTH-1:0]   alu_lo, sum_ab, dif_ab;
  logic [SHAMT_W-1:0] shamt;
  logic [2*WIDTH-1:0] rot_r, rot_l;

  assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));
  assign sum_ab   = a + b;
  assign dif_ab   = a - b;
  assign shamt    = b[SHAMT_W-1:0];
  // Rotates shift a doubled copy of a, so amount 0 needs no special case.
  assign rot_r    = {a, a} >> shamt;
  assign rot_l    = {a, a} << shamt;

  // Single-cycle operations
  always_comb begin
    alu_lo = '0;
    case (opcode)
      OP_LD, OP_LDI, OP_ADD, OP_ADDI: alu_lo = sum_ab;
      OP_SUB:                         alu_lo = dif_ab;
      OP_AND, OP_ANDI:                alu_lo = a & b;
      OP_OR, OP_ORI:                  alu_lo = a | b;
      OP_SHR:                         alu_lo = a >> shamt;
      OP_SHRA:                        alu_lo = $signed(a) >>> shamt;
      OP_SHL:                         alu_lo = a << shamt;
      OP_ROR:                         alu_lo = rot_r[WIDTH-1:0];
      OP_ROL:                         alu_lo = rot_l[2*WIDTH-1:WIDTH];
      OP_NEG:                         alu_lo = -b;
      OP_NOT:                         alu_lo = ~b;
      OP_JR, OP_JAL:                  alu_lo = a;
      default:                        alu_lo = '0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (opcode == OP_MUL)                     state_d = S_MUL;
        else if (opcode == OP_DIV && b != '0)     state_d = S_DIV;
        else                                      state_d = S_EXEC;
      end
      S_EXEC: state_d = S_IDLE;
      S_MUL:  if (cnt_last) state_d = S_EXEC;
      S_DIV:  if (cnt_last) state_d = S_FIX;
      S_FIX:  state_d = S_EXEC;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    done = (state_q == S_EXEC);
  end

  // Datapath next-state
  always_comb begin
    logic [WIDTH:0]   m_ext, booth_sum, r_sh, r_diff;
    logic [WIDTH-1:0] rem_fix, quo_fix;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    a_neg_d = a_neg_q;
    q_neg_d = q_neg_q;
    dbz_d   = dbz_q;
    wr_res  = 1'b0;
    res_new = '0;
    m_ext     = {opnd_q[WIDTH-1], opnd_q};
    booth_sum = hi_q;
    r_sh      = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    r_diff    = r_sh - {1'b0, opnd_q};
    rem_fix   = a_neg_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
    quo_fix   = q_neg_q ? -lo_q : lo_q;
    case (state_q)
      S_IDLE: if (start) begin
        dbz_d = 1'b0;
        cnt_d = '0;
        if (opcode == OP_MUL) begin
          opnd_d = a;
          hi_d   = '0;
          lo_d   = b;
          qm1_d  = 1'b0;
        end else if (opcode == OP_DIV) begin
          if (b == '0) begin
            wr_res  = 1'b1;
            res_new = {a, {WIDTH{1'b1}}};
            dbz_d   = 1'b1;
          end else begin
            // Divide magnitudes; signs are restored in S_FIX.
            opnd_d  = b[WIDTH-1] ? -b : b;
            hi_d    = '0;
            lo_d    = a[WIDTH-1] ? -a : a;
            a_neg_d = a[WIDTH-1];
            q_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
          end
        end else begin
          wr_res  = 1'b1;
          res_new = {{WIDTH{1'b0}}, alu_lo};
        end
      end
      S_MUL: begin
        // Accumulator is WIDTH+1 bits so subtracting the most-negative multiplicand cannot overflow.
        case ({lo_q[0], qm1_q})
          2'b01:   booth_sum = hi_q + m_ext;
          2'b10:   booth_sum = hi_q - m_ext;
          default: booth_sum = hi_q;
        endcase
        hi_d  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
        qm1_d = lo_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) begin
          wr_res  = 1'b1;
          res_new = {hi_d[WIDTH-1:0], lo_d};
        end
      end
      S_DIV: begin
        if (r_diff[WIDTH]) begin
          hi_d = r_sh;
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end else begin
          hi_d = r_diff;
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
      end
      S_FIX: begin
        wr_res  = 1'b1;
        res_new = {rem_fix, quo_fix};
      end
      default: ;
    endcase
    result_d = wr_res ? res_new : result_q;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      a_neg_q  <= 1'b0;
      q_neg_q  <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      a_neg_q  <= a_neg_d;
      q_neg_q  <= q_neg_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result      = result_q;
  assign div_by_zero = dbz_q;

`ifdef ALU_FLAGS_EN
  logic alu_v;
  logic z_q, z_d, n_q, n_d, v_q, v_d;

  always_comb begin
    alu_v = 1'b0;
    case (opcode)
      OP_LD, OP_LDI, OP_ADD, OP_ADDI:
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ab[WIDTH-1] != a[WIDTH-1]);
      OP_NEG:
        alu_v = (b == {1'b1, {(WIDTH-1){1'b0}}});
      default: alu_v = 1'b0;
    endcase
  end

  // Only single-cycle results are written from S_IDLE, so mul/div always get v=0.
  always_comb begin
    z_d = z_q;
    n_d = n_q;
    v_d = v_q;
    if (wr_res) begin
      z_d = (res_new[WIDTH-1:0] == '0);
      n_d = res_new[WIDTH-1];
      v_d = (state_q == S_IDLE) && alu_v;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      z_q <= z_d;
      n_q <= n_d;
      v_q <= v_d;
    end
  end

  assign z = z_q;
  assign n = n_q;
  assign v = v_q;
`endif

endmodule
